// File: rtl/kmeans_pkg.sv
// Shared types and constants for the kMeans host transmitter/collector.
// Latency: n/a. Backpressure: n/a.
package kmeans_pkg;

    localparam int CLUSTER_SIZE_DEF = 4;
    localparam int DATA_SIZE_DEF    = 4096;
    localparam int COORD_W          = 8;
    localparam int WORD_W           = 2 * COORD_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_WAIT_RES,
        ST_DONE
    } state_t;

    function automatic int addr_w_for(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

endpackage

// File: rtl/kmeans_result_collector.sv
// Captures CLUSTER_SIZE result words into slots; flags completion or timeout.
// Latency: result_valid/timeout_err 1 cycle after the deciding cycle. Backpressure: none.
module kmeans_result_collector
    import kmeans_pkg::*;
#(
    parameter int CLUSTER_SIZE   = CLUSTER_SIZE_DEF,
    parameter int TIMEOUT_CYCLES = 1 << 24
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           active,
    input  logic                           km_out_valid,
    input  logic [WORD_W-1:0]              km_out_data,
    output logic                           complete,
    output logic                           expire,
    output logic                           result_valid,
    output logic [WORD_W*CLUSTER_SIZE-1:0] result_data,
    output logic                           timeout_err
);

    localparam int IDX_W = $clog2(CLUSTER_SIZE) + 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [IDX_W-1:0] idx;
    logic [TMO_W-1:0] tmo_cnt;

    // Completion has priority over the timeout when both land in one cycle.
    assign complete = active && km_out_valid && (idx == IDX_W'(CLUSTER_SIZE - 1));
    assign expire   = active && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            tmo_cnt      <= '0;
            result_valid <= 1'b0;
            result_data  <= '0;
            timeout_err  <= 1'b0;
        end else begin
            result_valid <= complete;
            timeout_err  <= expire && !complete;
            if (clear) begin
                idx     <= '0;
                tmo_cnt <= '0;
            end else if (active) begin
                tmo_cnt <= tmo_cnt + 1'b1;
                if (km_out_valid && (idx < IDX_W'(CLUSTER_SIZE))) begin
                    result_data[int'(idx)*WORD_W +: WORD_W] <= km_out_data;
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/kmeans_stream_tx.sv
// Streams centroids+points from source memory to the kMeans core and collects the centroids.
// Latency: word k on km_in_* 2 cycles after its address. Backpressure: none, stream is gapless.
module kmeans_stream_tx
    import kmeans_pkg::*;
#(
    parameter int CLUSTER_SIZE   = CLUSTER_SIZE_DEF,
    parameter int DATA_SIZE      = DATA_SIZE_DEF,
    parameter int ADDR_W         = addr_w_for(CLUSTER_SIZE + DATA_SIZE),
    parameter int TIMEOUT_CYCLES = 1 << 24
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           busy,
    output logic                           mem_rd,
    output logic [ADDR_W-1:0]              mem_addr,
    input  logic [WORD_W-1:0]              mem_rdata,
    output logic                           km_in_valid,
    output logic [WORD_W-1:0]              km_in_data,
    input  logic                           km_out_valid,
    input  logic [WORD_W-1:0]              km_out_data,
    output logic                           result_valid,
    output logic [WORD_W*CLUSTER_SIZE-1:0] result_data,
    output logic                           timeout_err
);

    localparam int               TOTAL     = CLUSTER_SIZE + DATA_SIZE;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);

    state_t state;
    logic   rd_vld;
    logic   drain_exit;
    logic   complete;
    logic   expire;

    // Last word is on km_in_* and nothing is left in the read pipeline.
    assign drain_exit = (state == ST_DRAIN) && km_in_valid && !rd_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            mem_rd      <= 1'b0;
            mem_addr    <= '0;
            rd_vld      <= 1'b0;
            km_in_valid <= 1'b0;
            km_in_data  <= '0;
        end else begin
            rd_vld      <= mem_rd;
            km_in_valid <= rd_vld;
            km_in_data  <= rd_vld ? mem_rdata : '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        busy     <= 1'b1;
                        mem_rd   <= 1'b1;
                        mem_addr <= '0;
                    end
                end
                ST_FETCH: begin
                    if (mem_addr == LAST_ADDR) begin
                        mem_rd <= 1'b0;
                        state  <= ST_DRAIN;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (drain_exit) begin
                        state <= ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (complete) begin
                        state <= ST_DONE;
                    end else if (expire) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    mem_rd <= 1'b0;
                end
            endcase
        end
    end

    kmeans_result_collector #(
        .CLUSTER_SIZE   (CLUSTER_SIZE),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_collector (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (drain_exit),
        .active       (state == ST_WAIT_RES),
        .km_out_valid (km_out_valid),
        .km_out_data  (km_out_data),
        .complete     (complete),
        .expire       (expire),
        .result_valid (result_valid),
        .result_data  (result_data),
        .timeout_err  (timeout_err)
    );

endmodule

// File: doc/kmeans_stream_tx.md
Name: kmeans_stream_tx

Overview:
Host-side transmitter and result collector for the kMeans accelerator. On `start`, it streams one frame from a synchronous source memory onto the accelerator input (`in_valid` / `in_data` protocol). The frame is CLUSTER_SIZE initial centroids followed by DATA_SIZE points, with `in_valid` held continuously high. It then captures the CLUSTER_SIZE centroid words returned on the `out_valid` / `out_data` side and presents them as one packed result. It sits between the test/host memory and the kMeans core.

Parameters:
CLUSTER_SIZE, 4, number of centroid words sent first and received back
DATA_SIZE, 4096, number of point words following the centroids
ADDR_W, 13, source memory address width; must satisfy 2^ADDR_W >= CLUSTER_SIZE+DATA_SIZE
TIMEOUT_CYCLES, 2^24, maximum cycles from end of stream to last result word

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to send a frame; ignored unless idle
busy  out  1  high from the cycle after an accepted start until return to IDLE
mem_rd  out  1  source memory read enable
mem_addr  out  ADDR_W  source memory word address
mem_rdata  in  16  read data, valid exactly 1 cycle after mem_rd
km_in_valid  out  1  to kMeans in_valid
km_in_data  out  16  to kMeans in_data, {x[15:8], y[7:0]}
km_out_valid  in  1  from kMeans out_valid
km_out_data  in  16  from kMeans out_data
result_valid  out  1  one-cycle pulse; result_data is valid in this cycle
result_data  out  16*CLUSTER_SIZE  centroid k in bits [16k+15:16k]
timeout_err  out  1  one-cycle pulse when results do not arrive in time

Behaviour:
- Reset: all outputs are 0, the FSM goes to IDLE and all counters are cleared. Reset asserted mid-frame drops `km_in_valid` immediately.
- All outputs are registered. There is no combinational path from any input to any output.
- Let TOTAL = CLUSTER_SIZE + DATA_SIZE.
- FSM states: IDLE, FETCH, DRAIN, WAIT_RES, DONE.
- IDLE:
  - `start` = 1 → FETCH. `busy` rises on the next edge.
  - `km_out_valid` is ignored.
- FETCH:
  - `mem_rd` = 1 every cycle.
  - `mem_addr` runs 0, 1, …, TOTAL-1, one address per cycle, with no stalls.
  - After issuing address TOTAL-1 → DRAIN.
- Read data path:
  - A read-valid pipeline flag follows `mem_rd` by 1 cycle.
  - `mem_rdata` is registered into `km_in_data`, and `km_in_valid` is set the same cycle.
  - Word k therefore appears on `km_in_*` 2 cycles after its address is issued.
  - `km_in_valid` is high for exactly TOTAL consecutive cycles. No gaps are allowed: a gap terminates the kMeans input phase.
- DRAIN:
  - `mem_rd` = 0; wait until the last word has been presented on `km_in_*`.
  - Then force `km_in_valid` = 0 and `km_in_data` = 0 → WAIT_RES.
  - Clear the timeout counter and the result index.
- WAIT_RES:
  - Each cycle with `km_out_valid` = 1 stores `km_out_data` into slot[idx] and increments idx (width clog2(CLUSTER_SIZE)+1).
  - Gaps between result words are tolerated.
  - When slot CLUSTER_SIZE-1 is written → DONE.
  - The timeout counter increments every cycle. On reaching TIMEOUT_CYCLES-1 without completion: pulse `timeout_err`, do not pulse `result_valid`, → IDLE.
  - If the last result word arrives in the same cycle the counter hits its limit, completion wins.
- DONE:
  - Pulse `result_valid` for 1 cycle with `result_data` = {slot3, slot2, slot1, slot0} → IDLE.
  - `busy` falls on the same edge `result_valid` falls.
  - `result_data` holds its value until the next frame's first captured word.
- Ignored inputs:
  - `km_out_valid` words beyond CLUSTER_SIZE in a frame.
  - `km_out_valid` in FETCH or DRAIN (a protocol violation; not stored).
  - `start` while `busy`.
- Back-to-back frames: a `start` in the cycle `result_valid` is high is ignored. `start` is accepted from the following cycle. This guarantees at least one `km_in_valid`-low cycle between frames.

Decomposition:
- Shared package `kmeans_pkg`:
  - CLUSTER_SIZE and DATA_SIZE defaults
  - coordinate width (8) and word width (16)
  - FSM state enum
  - ADDR_W derivation helper
- Sub-module `kmeans_result_collector`:
  - slot registers, index counter, timeout counter
  - `result_valid` / `timeout_err` generation
- The top level holds the FSM, the address counter and the read pipeline.

Test Plan:
- Memory preloaded with addr[15:0] as data; start at cycle 10 → `km_in_valid` high for exactly 4100 consecutive cycles starting at cycle 13; `km_in_data` = 0x0000…0x1003 in order; `mem_rd` never high after address 0x1003.
- After the stream, drive `km_out_valid` for 4 cycles with 0x1020, 0x3040, 0x5060, 0x7080 → one `result_valid` pulse with `result_data` = 0x7080_5060_3040_1020; `busy` low the next cycle.
- Result words delivered with 3-cycle gaps, plus a 5th word 0xFFFF → same result; the 5th word is ignored; `result_valid` pulses once.
- TIMEOUT_CYCLES = 100, only 2 result words returned → `timeout_err` pulses 100 cycles after DRAIN exit; no `result_valid`; next `start` is accepted.
- `start` pulsed at address 50 mid-FETCH, and `km_out_valid` asserted during FETCH → address sequence unaffected; stray word not captured.
- `rst_n` dropped at address 2000 → `km_in_valid`, `mem_rd` and `busy` go 0 asynchronously; after release, a new start streams again from address 0.
